pwm_ramp_ctrl: RTL and testbench

Sequencer that sits in front of `pwm_driver` and owns its `pwm_period`/`pwm_duty` inputs. It accepts target period/duty commands over a valid/ready handshake and ramps duty toward the target in fixed steps. Updates are applied only at PWM period boundaries, so the driver never sees a mid-period change. Used for soft-start and smooth brightness/speed transitions.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_period_timer.sv | 44 ++++
 rtl/pwm_ramp_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and default widths for the PWM ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int PWM_SIZE_DEFAULT = 16;
    localparam int DIV_SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } pwm_ramp_state_e;

    typedef struct packed {
        logic [PWM_SIZE_DEFAULT-1:0] period;
        logic [PWM_SIZE_DEFAULT-1:0] duty;
        logic [PWM_SIZE_DEFAULT-1:0] step;
        logic [DIV_SIZE_DEFAULT-1:0] div;
    } pwm_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pwm_period_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_period_timer
// Brief    : Free-running period counter; flags the last cycle of each period
//            and emits a registered pulse on the first cycle of the next one.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int PWM_SIZE = PWM_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_SIZE-1:0] period,
    output logic                boundary,
    output logic                period_start
);

    localparam logic [PWM_SIZE-1:0] c_ONE = {{(PWM_SIZE-1){1'b0}}, 1'b1};

    logic [PWM_SIZE-1:0] r_cnt;
    logic                r_period_start;

    // A zero period degenerates to a boundary on every cycle.
    assign boundary     = (period == '0) || (r_cnt == period - c_ONE);
    assign period_start = r_period_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= boundary;
            if (boundary) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Brief    : Ramps pwm_driver duty toward a commanded target in fixed steps,
//            updating period/duty only at PWM period boundaries.
//            Optional: define PWM_RAMP_IRQ_EN to add the done_irq output.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PWM_SIZE = PWM_SIZE_DEFAULT,
    parameter int DIV_SIZE = DIV_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_SIZE-1:0] cmd_period,
    input  logic [PWM_SIZE-1:0] cmd_duty,
    input  logic [PWM_SIZE-1:0] cmd_step,
    input  logic [DIV_SIZE-1:0] cmd_div,
    output logic [PWM_SIZE-1:0] pwm_period,
    output logic [PWM_SIZE-1:0] pwm_duty,
    output logic                period_start,
    output logic                busy
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic                done_irq
`endif
);

    localparam logic [PWM_SIZE-1:0] c_STEP_MIN = {{(PWM_SIZE-1){1'b0}}, 1'b1};
    localparam logic [DIV_SIZE-1:0] c_DIV_ONE  = {{(DIV_SIZE-1){1'b0}}, 1'b1};

    pwm_ramp_state_e     r_state;
    logic [PWM_SIZE-1:0] r_tgt_period;
    logic [PWM_SIZE-1:0] r_tgt_duty;
    logic [PWM_SIZE-1:0] r_step;
    logic [DIV_SIZE-1:0] r_div;
    logic [DIV_SIZE-1:0] r_div_cnt;
    logic [PWM_SIZE-1:0] r_pwm_period;
    logic [PWM_SIZE-1:0] r_pwm_duty;

    logic                w_boundary;
    logic [PWM_SIZE:0]   w_duty_x;
    logic [PWM_SIZE:0]   w_tgt_x;
    logic [PWM_SIZE:0]   w_step_x;
    logic [PWM_SIZE:0]   w_up;
    logic [PWM_SIZE:0]   w_gap;
    logic [PWM_SIZE-1:0] w_stepped;
    logic [PWM_SIZE-1:0] w_sel;
    logic [PWM_SIZE-1:0] w_next_duty;
    logic                w_done;

    pwm_period_timer #(
        .PWM_SIZE (PWM_SIZE)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .period       (r_pwm_period),
        .boundary     (w_boundary),
        .period_start (period_start)
    );

    assign cmd_ready  = (r_state != RAMP);
    assign busy       = (r_state == RAMP);
    assign pwm_period = r_pwm_period;
    assign pwm_duty   = r_pwm_duty;

    // One extra bit keeps duty+step and duty-target from wrapping.
    assign w_duty_x = {1'b0, r_pwm_duty};
    assign w_tgt_x  = {1'b0, r_tgt_duty};
    assign w_step_x = {1'b0, r_step};
    assign w_up     = w_duty_x + w_step_x;
    assign w_gap    = w_duty_x - w_tgt_x;

    always_comb begin
        w_stepped = r_pwm_duty;
        if (r_pwm_duty < r_tgt_duty) begin
            w_stepped = (w_up >= w_tgt_x) ? r_tgt_duty : w_up[PWM_SIZE-1:0];
        end else if (r_pwm_duty > r_tgt_duty) begin
            w_stepped = (w_gap <= w_step_x) ? r_tgt_duty : (r_pwm_duty - r_step);
        end
    end

    assign w_sel       = (r_div_cnt == '0) ? w_stepped : r_pwm_duty;
    assign w_next_duty = (w_sel > r_tgt_period) ? r_tgt_period : w_sel;
    assign w_done      = (r_state == RAMP) && w_boundary && (w_next_duty == r_tgt_duty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tgt_period <= '0;
            r_tgt_duty   <= '0;
            r_step       <= '0;
            r_div        <= '0;
            r_div_cnt    <= '0;
            r_pwm_period <= '0;
            r_pwm_duty   <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (cmd_valid) begin
                        r_tgt_period <= cmd_period;
                        r_tgt_duty   <= (cmd_duty > cmd_period) ? cmd_period : cmd_duty;
                        r_step       <= (cmd_step == '0) ? c_STEP_MIN : cmd_step;
                        r_div        <= cmd_div;
                        r_div_cnt    <= '0;
                        r_state      <= RAMP;
                    end
                end
                RAMP: begin
                    if (w_boundary) begin
                        r_pwm_period <= r_tgt_period;
                        r_pwm_duty   <= w_next_duty;
                        r_div_cnt    <= (r_div_cnt == '0) ? r_div : (r_div_cnt - c_DIV_ONE);
                        if (w_done) begin
                            r_state <= HOLD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    logic r_done_irq;

    assign done_irq = r_done_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_irq <= 1'b0;
        end else begin
            r_done_irq <= w_done;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Brief    : Directed, table-driven self-checking bench for pwm_ramp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_period = '0;
    logic [W-1:0] cmd_duty = '0;
    logic [W-1:0] cmd_step = '0;
    logic [D-1:0] cmd_div = '0;
    logic [W-1:0] pwm_period;
    logic [W-1:0] pwm_duty;
    logic         period_start;
    logic         busy;
`ifdef PWM_RAMP_IRQ_EN
    logic         done_irq;
`endif

    pwm_ramp_ctrl #(
        .PWM_SIZE (W),
        .DIV_SIZE (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_period   (cmd_period),
        .cmd_duty     (cmd_duty),
        .cmd_step     (cmd_step),
        .cmd_div      (cmd_div),
        .pwm_period   (pwm_period),
        .pwm_duty     (pwm_duty),
        .period_start (period_start),
        .busy         (busy)
`ifdef PWM_RAMP_IRQ_EN
        ,
        .done_irq     (done_irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] dlog [16];
    logic [W-1:0] plog [16];
    int           tlog [16];

    typedef struct {
        pwm_cmd_t     cmd;
        int           exp_upd;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_period;
        logic [W-1:0] exp_duty;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pwm_cmd_t c);
        cmd_period = c.period;
        cmd_duty   = c.duty;
        cmd_step   = c.step;
        cmd_div    = c.div;
        cmd_valid  = 1'b1;
    endtask

    task automatic send(input pwm_cmd_t c);
        int k;
        drive(c);
        k = 0;
        while (!cmd_ready && k < 200) begin
            tick();
            k++;
        end
        if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Logs every boundary update until busy drops.
    task automatic run_ramp(output int nupd);
        logic fin;
        nupd = 0;
        fin  = 1'b0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            tick();
            if (period_start) begin
                if (nupd < 16) begin
                    dlog[nupd] = pwm_duty;
                    plog[nupd] = pwm_period;
                    tlog[nupd] = cyc;
                end
                nupd++;
            end
            if (!busy) begin
                fin = 1'b1;
                chk("ready_at_done", 32'(cmd_ready), 32'd1);
`ifdef PWM_RAMP_IRQ_EN
                chk("done_irq_pulse", 32'(done_irq), 32'd1);
`endif
            end
        end
        if (!fin) chk("ramp_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int           nupd;
        int           bad;
        int           k;
        pwm_cmd_t     c;

        vecs[0] = '{cmd: '{period: 16'd10, duty: 16'd12, step: 16'd3,      div: 8'd0}, exp_upd: 3, exp_first: 16'd5,  exp_period: 16'd10, exp_duty: 16'd10};
        vecs[1] = '{cmd: '{period: 16'd4,  duty: 16'd9,  step: 16'd1,      div: 8'd0}, exp_upd: 1, exp_first: 16'd4,  exp_period: 16'd4,  exp_duty: 16'd4};
        vecs[2] = '{cmd: '{period: 16'd4,  duty: 16'd4,  step: 16'd5,      div: 8'd2}, exp_upd: 1, exp_first: 16'd4,  exp_period: 16'd4,  exp_duty: 16'd4};
        vecs[3] = '{cmd: '{period: 16'd20, duty: 16'd19, step: 16'hFFFF,   div: 8'd0}, exp_upd: 1, exp_first: 16'd19, exp_period: 16'd20, exp_duty: 16'd19};
        vecs[4] = '{cmd: '{period: 16'd20, duty: 16'd1,  step: 16'hFFFE,   div: 8'd0}, exp_upd: 1, exp_first: 16'd1,  exp_period: 16'd20, exp_duty: 16'd1};
        vecs[5] = '{cmd: '{period: 16'd0,  duty: 16'd0,  step: 16'd0,      div: 8'd0}, exp_upd: 1, exp_first: 16'd0,  exp_period: 16'd0,  exp_duty: 16'd0};
        vecs[6] = '{cmd: '{period: 16'd6,  duty: 16'd5,  step: 16'd2,      div: 8'd2}, exp_upd: 7, exp_first: 16'd2,  exp_period: 16'd6,  exp_duty: 16'd5};

        // Reset values, then idle with period 0.
        repeat (3) tick();
        chk("rst_period", 32'(pwm_period), 32'd0);
        chk("rst_duty", 32'(pwm_duty), 32'd0);
        chk("rst_pstart", 32'(period_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm_period !== '0 || pwm_duty !== '0 || busy !== 1'b0 ||
                cmd_ready !== 1'b1 || period_start !== 1'b1) bad++;
        end
        chk("idle_bad_cycles", 32'(bad), 32'd0);

        // Soft-start 0 -> 8 in steps of 2 on consecutive boundaries.
        c = '{period: 16'd16, duty: 16'd8, step: 16'd2, div: 8'd0};
        send(c);
        run_ramp(nupd);
        chk("up_updates", 32'(nupd), 32'd4);
        chk("up_period_first", 32'(plog[0]), 32'd16);
        chk("up_d0", 32'(dlog[0]), 32'd2);
        chk("up_d1", 32'(dlog[1]), 32'd4);
        chk("up_d2", 32'(dlog[2]), 32'd6);
        chk("up_d3", 32'(dlog[3]), 32'd8);
        chk("up_spacing", 32'(tlog[2] - tlog[1]), 32'd16);
        chk("up_busy_end", 32'(busy), 32'd0);

        // Ramp down 8 -> 2, step 4, div 1: steps two periods apart.
        c = '{period: 16'd16, duty: 16'd2, step: 16'd4, div: 8'd1};
        send(c);
        run_ramp(nupd);
        chk("dn_updates", 32'(nupd), 32'd3);
        chk("dn_d0", 32'(dlog[0]), 32'd4);
        chk("dn_d1", 32'(dlog[1]), 32'd4);
        chk("dn_d2", 32'(dlog[2]), 32'd2);
        chk("dn_step_spacing", 32'(tlog[2] - tlog[0]), 32'd32);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].cmd);
            run_ramp(nupd);
            chk($sformatf("vec%0d_updates", i), 32'(nupd), 32'(vecs[i].exp_upd));
            chk($sformatf("vec%0d_first", i), 32'(dlog[0]), 32'(vecs[i].exp_first));
            chk($sformatf("vec%0d_period", i), 32'(pwm_period), 32'(vecs[i].exp_period));
            chk($sformatf("vec%0d_duty", i), 32'(pwm_duty), 32'(vecs[i].exp_duty));
        end

        // Stall: a second command held valid through the ramp is taken at HOLD.
        c = '{period: 16'd8, duty: 16'd1, step: 16'd1, div: 8'd0};
        send(c);
        c = '{period: 16'd8, duty: 16'd7, step: 16'd3, div: 8'd0};
        drive(c);
        bad = 0;
        k = 0;
        while (busy && k < 500) begin
            if (cmd_ready !== 1'b0) bad++;
            tick();
            k++;
        end
        chk("stall_ready_low", 32'(bad), 32'd0);
        chk("stall_done", 32'(busy), 32'd0);
        chk("stall_ready_hold", 32'(cmd_ready), 32'd1);
        chk("stall_duty_a", 32'(pwm_duty), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("stall_taken", 32'(busy), 32'd1);
        run_ramp(nupd);
        chk("stall_b_updates", 32'(nupd), 32'd2);
        chk("stall_b_duty", 32'(pwm_duty), 32'd7);

        // Reset mid-ramp at duty 6 of 12.
        c = '{period: 16'd16, duty: 16'd0, step: 16'd8, div: 8'd0};
        send(c);
        run_ramp(nupd);
        c = '{period: 16'd16, duty: 16'd12, step: 16'd2, div: 8'd0};
        send(c);
        k = 0;
        while (pwm_duty !== 16'd6 && k < 200) begin
            tick();
            k++;
        end
        chk("mid_duty6", 32'(pwm_duty), 32'd6);
        #2 rst = 1'b0;
        #1;
        chk("arst_period", 32'(pwm_period), 32'd0);
        chk("arst_duty", 32'(pwm_duty), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_pstart", 32'(period_start), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || pwm_duty !== '0 || pwm_period !== '0) bad++;
        end
        chk("no_resume", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
